overlay_window_ctrl: RTL and testbench

- Register-configurable rectangular overlay controller for the RGB pixel stream (sop/eop/valid framing).
- Tracks pixel column and line position, holds the overlay window and colour in double-buffered registers, and substitutes the overlay colour inside the window.
- Sits inline in the video pipe ahead of the HDR processing stages and is programmed through a simple write port.

---
 rtl/overlay_window_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_overlay_window_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_window_ctrl.sv
// overlay_window_ctrl: rectangular colour overlay on an sop/eop/valid RGB stream.
// Tracks column/line position, holds a double-buffered window (staging -> active)
// and replaces pixels inside the window with a flat colour. One cycle of latency.
// Optional feature macro: OVERLAY_MOTION_EN (window bounces one step per frame).
module overlay_window_ctrl #(
  parameter int W           = 10,
  parameter int CW          = 12,
  parameter int FRAME_LINES = 720,
  parameter int MAX_COL     = 1279
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          sop_i,
  input  logic          eop_i,
  input  logic          valid_i,
  input  logic [W-1:0]  r_i,
  input  logic [W-1:0]  g_i,
  input  logic [W-1:0]  b_i,
  output logic          sop_o,
  output logic          eop_o,
  output logic          valid_o,
  output logic [W-1:0]  r_o,
  output logic [W-1:0]  g_o,
  output logic [W-1:0]  b_o,
  output logic          frame_done_o,
  output logic          protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2
  } state_t;

  localparam logic [CW-1:0] COL_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] LAST_LINE = CW'(FRAME_LINES - 1);
  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] col_r, col_nxt_s, line_r, line_nxt_s, pix_col_s;
  logic          tracked_s, err_evt_s, eop_evt_s, last_line_s, in_win_s;
  logic          clr_s, load_s;
  logic [W-1:0]  pix_r_s, pix_g_s, pix_b_s;

  logic [CW-1:0] stg_x0_r, stg_x1_r, stg_y0_r, stg_y1_r;
  logic          stg_en_r;
  logic [W-1:0]  stg_colour_r;
  logic [CW-1:0] act_x0_r, act_x1_r, act_y0_r, act_y1_r;
  logic          act_en_r;
  logic [W-1:0]  act_colour_r;

  // Next-state decode, pixel column selection and framing-error detection
  always_comb begin
    state_nxt_s = state_r;
    tracked_s   = 1'b0;
    pix_col_s   = col_r;
    err_evt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_i && sop_i) begin
          tracked_s   = 1'b1;
          pix_col_s   = '0;
          state_nxt_s = eop_i ? HBLANK : LINE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LINE: begin
        if (valid_i) begin
          tracked_s = 1'b1;
          if (sop_i) begin
            // sop inside a line restarts it at column 0 on the same line
            pix_col_s = '0;
            err_evt_s = 1'b1;
          end else begin
            pix_col_s = col_r;
          end
          state_nxt_s = eop_i ? HBLANK : LINE;
        end else begin
          state_nxt_s = LINE;
        end
      end
      HBLANK: begin
        if (valid_i && sop_i) begin
          tracked_s   = 1'b1;
          pix_col_s   = '0;
          state_nxt_s = eop_i ? HBLANK : LINE;
        end else if (valid_i || eop_i) begin
          // stray pixel or eop between lines: flagged, counters left alone
          err_evt_s   = 1'b1;
          state_nxt_s = HBLANK;
        end else begin
          state_nxt_s = HBLANK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Counter next values: saturating column, wrapping line
  always_comb begin
    eop_evt_s   = tracked_s & eop_i;
    last_line_s = (line_r == LAST_LINE);
    if (tracked_s) begin
      col_nxt_s = (pix_col_s == COL_SAT) ? COL_SAT : (pix_col_s + ONE);
    end else begin
      col_nxt_s = col_r;
    end
    if (eop_evt_s) begin
      line_nxt_s = last_line_s ? '0 : (line_r + ONE);
    end else begin
      line_nxt_s = line_r;
    end
  end

  // Window hit test and output pixel selection
  always_comb begin
    in_win_s = tracked_s & act_en_r &
               (pix_col_s >= act_x0_r) & (pix_col_s <= act_x1_r) &
               (line_r >= act_y0_r) & (line_r <= act_y1_r);
    if (!valid_i) begin
      pix_r_s = '0;
      pix_g_s = '0;
      pix_b_s = '0;
    end else if (in_win_s) begin
      pix_r_s = act_colour_r;
      pix_g_s = act_colour_r;
      pix_b_s = act_colour_r;
    end else begin
      pix_r_s = r_i;
      pix_g_s = g_i;
      pix_b_s = b_i;
    end
  end

  assign clr_s  = cfg_we & (cfg_addr == 3'd4) & cfg_wdata[1];
  assign load_s = frame_done_o | (state_r == IDLE);

  // FSM state and position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      col_r   <= '0;
      line_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      line_r  <= line_nxt_s;
    end
  end

  // Staging register writes from the configuration port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_x0_r     <= '0;
      stg_x1_r     <= '0;
      stg_y0_r     <= '0;
      stg_y1_r     <= '0;
      stg_en_r     <= 1'b0;
      stg_colour_r <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    stg_x0_r     <= cfg_wdata;
        3'd1:    stg_x1_r     <= cfg_wdata;
        3'd2:    stg_y0_r     <= cfg_wdata;
        3'd3:    stg_y1_r     <= cfg_wdata;
        3'd4:    stg_en_r     <= cfg_wdata[0];
        3'd5:    stg_colour_r <= cfg_wdata[W-1:0];
        default: begin end
      endcase
    end
  end

`ifdef OVERLAY_MOTION_EN
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COL);

  logic          dirty_r, dx_neg_r, dy_neg_r, dx_neg_nxt_s, dy_neg_nxt_s, stage_wr_s;
  logic [CW-1:0] mv_x0_s, mv_x1_s, mv_y0_s, mv_y1_s;

  assign stage_wr_s = cfg_we & (cfg_addr <= 3'd5);

  // Direction for the next step (reverse at the frame edges) and translated window
  always_comb begin
    if (dx_neg_r) begin
      dx_neg_nxt_s = (act_x0_r != '0);
    end else begin
      dx_neg_nxt_s = (act_x1_r >= MAX_C);
    end
    if (dy_neg_r) begin
      dy_neg_nxt_s = (act_y0_r != '0);
    end else begin
      dy_neg_nxt_s = (act_y1_r >= LAST_LINE);
    end
    mv_x0_s = dx_neg_nxt_s ? (act_x0_r - ONE) : (act_x0_r + ONE);
    mv_x1_s = dx_neg_nxt_s ? (act_x1_r - ONE) : (act_x1_r + ONE);
    mv_y0_s = dy_neg_nxt_s ? (act_y0_r - ONE) : (act_y0_r + ONE);
    mv_y1_s = dy_neg_nxt_s ? (act_y1_r - ONE) : (act_y1_r + ONE);
  end

  // Active window: reload from staging after a write (or while idle), else step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x0_r     <= '0;
      act_x1_r     <= '0;
      act_y0_r     <= '0;
      act_y1_r     <= '0;
      act_en_r     <= 1'b0;
      act_colour_r <= '0;
      dx_neg_r     <= 1'b0;
      dy_neg_r     <= 1'b0;
      dirty_r      <= 1'b0;
    end else begin
      if (load_s) begin
        if ((state_r == IDLE) || dirty_r) begin
          act_x0_r     <= stg_x0_r;
          act_x1_r     <= stg_x1_r;
          act_y0_r     <= stg_y0_r;
          act_y1_r     <= stg_y1_r;
          act_en_r     <= stg_en_r;
          act_colour_r <= stg_colour_r;
          dx_neg_r     <= 1'b0;
          dy_neg_r     <= 1'b0;
        end else begin
          act_x0_r <= mv_x0_s;
          act_x1_r <= mv_x1_s;
          act_y0_r <= mv_y0_s;
          act_y1_r <= mv_y1_s;
          dx_neg_r <= dx_neg_nxt_s;
          dy_neg_r <= dy_neg_nxt_s;
        end
      end
      // a write coinciding with a load stays pending for the next boundary
      if (stage_wr_s) begin
        dirty_r <= 1'b1;
      end else if (load_s) begin
        dirty_r <= 1'b0;
      end
    end
  end
`else
  localparam int max_col_unused = MAX_COL;

  // Active window: copy staging at each frame boundary or while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x0_r     <= '0;
      act_x1_r     <= '0;
      act_y0_r     <= '0;
      act_y1_r     <= '0;
      act_en_r     <= 1'b0;
      act_colour_r <= '0;
    end else if (load_s) begin
      act_x0_r     <= stg_x0_r;
      act_x1_r     <= stg_x1_r;
      act_y0_r     <= stg_y0_r;
      act_y1_r     <= stg_y1_r;
      act_en_r     <= stg_en_r;
      act_colour_r <= stg_colour_r;
    end
  end
`endif

  // Registered outputs: delayed framing, substituted pixel, frame pulse, sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_o          <= 1'b0;
      eop_o          <= 1'b0;
      valid_o        <= 1'b0;
      r_o            <= '0;
      g_o            <= '0;
      b_o            <= '0;
      frame_done_o   <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      sop_o          <= sop_i;
      eop_o          <= eop_i;
      valid_o        <= valid_i;
      r_o            <= pix_r_s;
      g_o            <= pix_g_s;
      b_o            <= pix_b_s;
      frame_done_o   <= eop_evt_s & last_line_s;
      // a new error wins over a clear in the same cycle
      protocol_err_o <= err_evt_s | (protocol_err_o & ~clr_s);
    end
  end

endmodule

// File: tb/tb_overlay_window_ctrl.sv
// Scoreboard bench for overlay_window_ctrl with a reduced frame (8 lines of 20 pixels).
module tb_overlay_window_ctrl;
  localparam int W    = 10;
  localparam int CW   = 12;
  localparam int FL   = 8;
  localparam int MAXC = 19;
  localparam int LEN  = 20;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          cfg_we    = 1'b0;
  logic [2:0]    cfg_addr  = 3'd0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          sop_i     = 1'b0;
  logic          eop_i     = 1'b0;
  logic          valid_i   = 1'b0;
  logic [W-1:0]  r_i = '0, g_i = '0, b_i = '0;
  logic          sop_o, eop_o, valid_o, frame_done_o, protocol_err_o;
  logic [W-1:0]  r_o, g_o, b_o;

  overlay_window_ctrl #(.W(W), .CW(CW), .FRAME_LINES(FL), .MAX_COL(MAXC)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .sop_i(sop_i), .eop_i(eop_i), .valid_i(valid_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .frame_done_o(frame_done_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [1:0]    m_state;
  logic [CW-1:0] m_col, m_line;
  logic          m_fd, m_err;
  logic [CW-1:0] s_x0, s_x1, s_y0, s_y1, a_x0, a_x1, a_y0, a_y1;
  logic          s_en, a_en;
  logic [W-1:0]  s_col, a_col;
`ifdef OVERLAY_MOTION_EN
  logic          m_dirty, m_dxn, m_dyn;
`endif
  logic [34:0]   sb_q[$];
  int n_checks = 0, n_fail = 0, ovr_cnt = 0, m_ovr = 0, fd_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_col = '0; m_line = '0; m_fd = 1'b0; m_err = 1'b0;
    s_x0 = '0; s_x1 = '0; s_y0 = '0; s_y1 = '0; s_en = 1'b0; s_col = '0;
    a_x0 = '0; a_x1 = '0; a_y0 = '0; a_y1 = '0; a_en = 1'b0; a_col = '0;
`ifdef OVERLAY_MOTION_EN
    m_dirty = 1'b0; m_dxn = 1'b0; m_dyn = 1'b0;
`endif
    sb_q.delete();
  endtask

  // predicts the outputs for the inputs currently driven, then advances the model
  task automatic model_step();
    logic tracked, perr, eop_evt, inwin, clr, load, new_fd;
    logic [CW-1:0] pc;
    logic [W-1:0] orr, og, ob;
    tracked = 1'b0; perr = 1'b0; pc = m_col;
    case (m_state)
      2'd0: begin
        if (valid_i && sop_i) begin tracked = 1'b1; pc = '0; end
      end
      2'd1: begin
        if (valid_i) begin
          tracked = 1'b1;
          if (sop_i) begin pc = '0; perr = 1'b1; end
        end
      end
      default: begin
        if (valid_i && sop_i) begin tracked = 1'b1; pc = '0; end
        else if (valid_i || eop_i) perr = 1'b1;
      end
    endcase
    eop_evt = tracked && eop_i;
    inwin = tracked && a_en && (pc >= a_x0) && (pc <= a_x1) && (m_line >= a_y0) && (m_line <= a_y1);
    if (inwin) m_ovr++;
    orr = !valid_i ? '0 : (inwin ? a_col : r_i);
    og  = !valid_i ? '0 : (inwin ? a_col : g_i);
    ob  = !valid_i ? '0 : (inwin ? a_col : b_i);
    clr = cfg_we && (cfg_addr == 3'd4) && cfg_wdata[1];
    load = m_fd || (m_state == 2'd0);
    new_fd = eop_evt && (m_line == CW'(FL - 1));
    m_err = perr || (m_err && !clr);
    sb_q.push_back({valid_i, sop_i, eop_i, orr, og, ob, new_fd, m_err});
`ifdef OVERLAY_MOTION_EN
    if (load) begin
      if ((m_state == 2'd0) || m_dirty) begin
        a_x0 = s_x0; a_x1 = s_x1; a_y0 = s_y0; a_y1 = s_y1; a_en = s_en; a_col = s_col;
        m_dxn = 1'b0; m_dyn = 1'b0;
      end else begin
        if (m_dxn) m_dxn = (a_x0 != '0); else m_dxn = (a_x1 >= CW'(MAXC));
        if (m_dyn) m_dyn = (a_y0 != '0); else m_dyn = (a_y1 >= CW'(FL - 1));
        if (m_dxn) begin a_x0 = a_x0 - 1'b1; a_x1 = a_x1 - 1'b1; end
        else begin a_x0 = a_x0 + 1'b1; a_x1 = a_x1 + 1'b1; end
        if (m_dyn) begin a_y0 = a_y0 - 1'b1; a_y1 = a_y1 - 1'b1; end
        else begin a_y0 = a_y0 + 1'b1; a_y1 = a_y1 + 1'b1; end
      end
      m_dirty = 1'b0;
    end
    if (cfg_we && (cfg_addr <= 3'd5)) m_dirty = 1'b1;
`else
    if (load) begin
      a_x0 = s_x0; a_x1 = s_x1; a_y0 = s_y0; a_y1 = s_y1; a_en = s_en; a_col = s_col;
    end
`endif
    if (cfg_we) begin
      case (cfg_addr)
        3'd0: s_x0 = cfg_wdata;
        3'd1: s_x1 = cfg_wdata;
        3'd2: s_y0 = cfg_wdata;
        3'd3: s_y1 = cfg_wdata;
        3'd4: s_en = cfg_wdata[0];
        3'd5: s_col = cfg_wdata[W-1:0];
        default: begin end
      endcase
    end
    if (tracked) begin
      m_col = (pc == {CW{1'b1}}) ? pc : pc + 1'b1;
      m_state = eop_i ? 2'd2 : 2'd1;
    end
    if (eop_evt) m_line = (m_line == CW'(FL - 1)) ? '0 : m_line + 1'b1;
    m_fd = new_fd;
  endtask

  // one clock: drive at negedge, predict, compare the registered result after posedge
  task automatic cyc(input logic we, input logic [2:0] a, input logic [CW-1:0] d,
                     input logic s, input logic e, input logic v);
    logic [34:0] exp_v, obs_v;
    @(negedge clk);
    cfg_we = we; cfg_addr = a; cfg_wdata = d;
    sop_i = s; eop_i = e; valid_i = v;
    r_i = W'($urandom_range(0, 200));
    g_i = W'($urandom_range(0, 200));
    b_i = W'($urandom_range(0, 200));
    model_step();
    @(posedge clk);
    #1;
    obs_v = {valid_o, sop_o, eop_o, r_o, g_o, b_o, frame_done_o, protocol_err_o};
    check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check_eq("pix_out", 64'(obs_v), 64'(exp_v));
    end
    if (valid_o && (r_o == W'(255))) ovr_cnt++;
    if (frame_done_o) fd_cnt++;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [CW-1:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic setup_window(input int x0, input int x1, input int y0, input int y1);
    cfg(3'd0, CW'(x0)); cfg(3'd1, CW'(x1)); cfg(3'd2, CW'(y0)); cfg(3'd3, CW'(y1));
    cfg(3'd5, CW'(255)); cfg(3'd4, CW'(1));
  endtask

  task automatic send_line(input bit gaps);
    for (int i = 0; i < LEN; i++) begin
      cyc(1'b0, 3'd0, '0, (i == 0), (i == LEN - 1), 1'b1);
      if (gaps && (i < LEN - 1) && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  // full frame; optionally rewrite X0/X1 after line wr_line
  task automatic send_frame(input bit gaps, input bit chk_fd, input int wr_line,
                            input int x0v, input int x1v);
    ovr_cnt = 0; m_ovr = 0; fd_cnt = 0;
    for (int l = 0; l < FL; l++) begin
      send_line(gaps);
      if (l == wr_line) begin cfg(3'd0, CW'(x0v)); cfg(3'd1, CW'(x1v)); end
    end
    idle(2);
    check_eq("ovr_count", 64'(ovr_cnt), 64'(m_ovr));
    if (chk_fd) check_eq("frame_done_cnt", 64'(fd_cnt), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cfg_we = 1'b0; sop_i = 1'b0; eop_i = 1'b0; valid_i = 1'b0;
    #1;
    check_eq("async_reset_outs",
             64'({valid_o, sop_o, eop_o, r_o, g_o, b_o, frame_done_o, protocol_err_o}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs",
             64'({valid_o, sop_o, eop_o, r_o, g_o, b_o, frame_done_o, protocol_err_o}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // reset mid-frame, then two clean frames with a 10x4 window
    setup_window(5, 14, 2, 5);
    for (int l = 0; l < 3; l++) send_line(1'b0);
    cyc(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
    do_reset();
    setup_window(5, 14, 2, 5);
    send_frame(1'b0, 1'b1, -1, 0, 0);
    check_eq("ovr_frame_a", 64'(ovr_cnt), 64'd40);
    send_frame(1'b0, 1'b1, -1, 0, 0);
    check_eq("ovr_frame_b", 64'(ovr_cnt), 64'd40);

    // double buffering: write during frame N, visible in frame N+1
    send_frame(1'b0, 1'b1, 1, 0, 9);
    send_frame(1'b0, 1'b1, -1, 0, 0);

    // empty window (X0 > X1)
    cfg(3'd0, CW'(10)); cfg(3'd1, CW'(5));
    send_frame(1'b0, 1'b1, -1, 0, 0);
    send_frame(1'b0, 1'b1, -1, 0, 0);
    check_eq("empty_win_cnt", 64'(ovr_cnt), 64'd0);

    // one-pixel line counts as a line and is not an error
    cfg(3'd0, CW'(2)); cfg(3'd1, CW'(3)); cfg(3'd2, CW'(0)); cfg(3'd3, CW'(6));
    fd_cnt = 0;
    cyc(1'b0, 3'd0, '0, 1'b1, 1'b1, 1'b1);
    idle(2);
    check_eq("one_px_err", 64'(protocol_err_o), 64'd0);
    for (int l = 0; l < FL - 1; l++) send_line(1'b0);
    check_eq("one_px_line_count", 64'(fd_cnt), 64'd1);

    // protocol errors: double sop, clear, clear vs. simultaneous error, stray eop
    cyc(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("perr_double_sop", 64'(protocol_err_o), 64'd1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b1);
    idle(1);
    cfg(3'd4, CW'(3));
    check_eq("perr_clear", 64'(protocol_err_o), 64'd0);
    cyc(1'b1, 3'd4, CW'(3), 1'b0, 1'b0, 1'b1);
    check_eq("perr_clear_vs_set", 64'(protocol_err_o), 64'd1);
    cfg(3'd4, CW'(3));
    check_eq("perr_clear2", 64'(protocol_err_o), 64'd0);
    cyc(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("perr_stray_eop", 64'(protocol_err_o), 64'd1);
    cfg(3'd4, CW'(3));

    // stalls: gapless frame then a frame with 1-3 cycle valid gaps
    do_reset();
    setup_window(5, 14, 2, 5);
    send_frame(1'b0, 1'b1, -1, 0, 0);
    check_eq("ovr_gapless", 64'(ovr_cnt), 64'd40);
    send_frame(1'b1, 1'b1, -1, 0, 0);
    check_eq("ovr_stalled", 64'(ovr_cnt), 64'd40);

`ifdef OVERLAY_MOTION_EN
    // moving window: from the left edge, then from the right edge
    do_reset();
    setup_window(0, 9, 0, 3);
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b1, -1, 0, 0);
    cfg(3'd0, CW'(10)); cfg(3'd1, CW'(MAXC));
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b1, -1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
